// File: rtl/timestamp_word_decoder_if.sv
// Bus bundle between the timestamp decoder, its upstream FWFT FIFO and the
// downstream timestamp consumer.
interface timestamp_word_decoder_if;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned TS_W   = 64;

  // Upstream FWFT FIFO side
  logic              FIFO_EMPTY;
  logic [WORD_W-1:0] FIFO_DATA;
  logic              FIFO_READ;

  // Downstream timestamp valid/ready side
  logic              TS_VALID;
  logic [TS_W-1:0]   TS_DATA;
  logic              TS_READY;

  // Decoder view
  modport master (
    input  FIFO_EMPTY,
    input  FIFO_DATA,
    output FIFO_READ,
    output TS_VALID,
    output TS_DATA,
    input  TS_READY
  );

  // Environment view (FIFO and consumer)
  modport slave (
    output FIFO_EMPTY,
    output FIFO_DATA,
    input  FIFO_READ,
    input  TS_VALID,
    input  TS_DATA,
    output TS_READY
  );
endinterface

// File: rtl/timestamp_word_decoder.sv
// Reassembles three-word timestamp groups popped from an FWFT FIFO into
// 64-bit timestamps and tracks foreign, sequence and monotonicity errors.
module timestamp_word_decoder #(
  parameter logic [3:0]  IDENTIFIER = 4'b0001,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 ENABLE,
  timestamp_word_decoder_if.master bus,
  output logic [31:0]          TS_CNT,
  output logic [CNT_WIDTH-1:0] FOREIGN_CNT,
  output logic [CNT_WIDTH-1:0] SEQ_ERR_CNT,
  output logic [CNT_WIDTH-1:0] MONO_ERR_CNT
);

  localparam int unsigned PART_W = 24;
  localparam int unsigned TOP_W  = 16;
  localparam int unsigned TS_W   = 64;

  localparam logic [3:0] TYP_W1 = 4'h1;
  localparam logic [3:0] TYP_W2 = 4'h2;
  localparam logic [3:0] TYP_W3 = 4'h3;

  typedef enum logic [1:0] {
    WAIT1 = 2'd0,
    WAIT2 = 2'd1,
    WAIT3 = 2'd2
  } state_t;

  state_t               state_q,   state_d;
  logic [PART_W-1:0]    lo_q,      lo_d;
  logic [PART_W-1:0]    mid_q,     mid_d;
  logic                 ts_valid_q, ts_valid_d;
  logic [TS_W-1:0]      ts_data_q, ts_data_d;
  logic [31:0]          ts_cnt_q,  ts_cnt_d;
  logic [CNT_WIDTH-1:0] foreign_q, foreign_d;
  logic [CNT_WIDTH-1:0] seq_q,     seq_d;
  logic [CNT_WIDTH-1:0] mono_q,    mono_d;
  logic [TS_W-1:0]      last_q,    last_d;
  logic                 last_vld_q, last_vld_d;

  logic                 pop_c;
  logic                 complete_c;
  logic                 seq_err_c;
  logic                 foreign_c;
  logic                 mono_err_c;
  logic [3:0]           word_id_c;
  logic [3:0]           word_typ_c;
  logic [PART_W-1:0]    payload_c;
  logic [TS_W-1:0]      new_ts_c;

  // Saturating increment for the error counters
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c,
                                                    input logic inc);
    if (inc && (c != '1)) begin
      return c + CNT_WIDTH'(1);
    end
    return c;
  endfunction

  // Field extraction and pop strobe; a held-back result stalls the FIFO
  always_comb begin
    word_id_c  = bus.FIFO_DATA[31:28];
    word_typ_c = bus.FIFO_DATA[27:24];
    payload_c  = bus.FIFO_DATA[23:0];
    new_ts_c   = {bus.FIFO_DATA[TOP_W-1:0], mid_q, lo_q};
    pop_c      = RST_N & ENABLE & ~bus.FIFO_EMPTY & ~(ts_valid_q & ~bus.TS_READY);
  end

  // Group-assembly FSM: next state, partial buffers and event strobes
  always_comb begin
    state_d    = state_q;
    lo_d       = lo_q;
    mid_d      = mid_q;
    complete_c = 1'b0;
    seq_err_c  = 1'b0;
    foreign_c  = 1'b0;

    if (pop_c) begin
      if (word_id_c != IDENTIFIER) begin
        foreign_c = 1'b1;
      end else begin
        case (state_q)
          WAIT1: begin
            if (word_typ_c == TYP_W1) begin
              lo_d    = payload_c;
              state_d = WAIT2;
            end else begin
              seq_err_c = 1'b1;
            end
          end
          WAIT2: begin
            if (word_typ_c == TYP_W2) begin
              mid_d   = payload_c;
              state_d = WAIT3;
            end else if (word_typ_c == TYP_W1) begin
              // A fresh first word restarts the group
              seq_err_c = 1'b1;
              lo_d      = payload_c;
              state_d   = WAIT2;
            end else begin
              seq_err_c = 1'b1;
              state_d   = WAIT1;
            end
          end
          WAIT3: begin
            if (word_typ_c == TYP_W3) begin
              // Word 3 carries only 16 timestamp bits; nonzero pad is malformed
              if (payload_c[23:16] == 8'h00) begin
                complete_c = 1'b1;
              end else begin
                seq_err_c = 1'b1;
              end
              state_d = WAIT1;
            end else if (word_typ_c == TYP_W1) begin
              seq_err_c = 1'b1;
              lo_d      = payload_c;
              state_d   = WAIT2;
            end else begin
              seq_err_c = 1'b1;
              state_d   = WAIT1;
            end
          end
          default: begin
            state_d = WAIT1;
          end
        endcase
      end
    end
  end

  // Output slot, monotonicity tracking and counters
  always_comb begin
    ts_valid_d = ts_valid_q;
    ts_data_d  = ts_data_q;
    last_d     = last_q;
    last_vld_d = last_vld_q;
    mono_err_c = 1'b0;

    if (complete_c) begin
      // Completion wins over a same-cycle acceptance so groups can stream back-to-back
      ts_valid_d = 1'b1;
      ts_data_d  = new_ts_c;
      mono_err_c = last_vld_q & (new_ts_c < last_q);
      last_d     = new_ts_c;
      last_vld_d = 1'b1;
    end else if (ts_valid_q && bus.TS_READY) begin
      ts_valid_d = 1'b0;
    end

    ts_cnt_d  = ts_cnt_q + 32'(complete_c);
    foreign_d = sat_inc(foreign_q, foreign_c);
    seq_d     = sat_inc(seq_q, seq_err_c);
    mono_d    = sat_inc(mono_q, mono_err_c);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q    <= WAIT1;
      lo_q       <= '0;
      mid_q      <= '0;
      ts_valid_q <= 1'b0;
      ts_data_q  <= '0;
      ts_cnt_q   <= '0;
      foreign_q  <= '0;
      seq_q      <= '0;
      mono_q     <= '0;
      last_q     <= '0;
      last_vld_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      lo_q       <= lo_d;
      mid_q      <= mid_d;
      ts_valid_q <= ts_valid_d;
      ts_data_q  <= ts_data_d;
      ts_cnt_q   <= ts_cnt_d;
      foreign_q  <= foreign_d;
      seq_q      <= seq_d;
      mono_q     <= mono_d;
      last_q     <= last_d;
      last_vld_q <= last_vld_d;
    end
  end

  assign bus.FIFO_READ = pop_c;
  assign bus.TS_VALID  = ts_valid_q;
  assign bus.TS_DATA   = ts_data_q;
  assign TS_CNT        = ts_cnt_q;
  assign FOREIGN_CNT   = foreign_q;
  assign SEQ_ERR_CNT   = seq_q;
  assign MONO_ERR_CNT  = mono_q;

endmodule

// File: tb/tb_timestamp_word_decoder.sv
// Randomized and directed bench for timestamp_word_decoder against a
// word-level reference model of the group format.
module tb_timestamp_word_decoder;

  localparam int unsigned CW   = 4;
  localparam int unsigned MAXC = (1 << CW) - 1;

  logic          CLK = 1'b0;
  logic          RST_N;
  logic          ENABLE;
  logic [31:0]   TS_CNT;
  logic [CW-1:0] FOREIGN_CNT, SEQ_ERR_CNT, MONO_ERR_CNT;

  timestamp_word_decoder_if bus();

  timestamp_word_decoder #(.IDENTIFIER(4'b0001), .CNT_WIDTH(CW)) dut (
    .CLK          (CLK),
    .RST_N        (RST_N),
    .ENABLE       (ENABLE),
    .bus          (bus),
    .TS_CNT       (TS_CNT),
    .FOREIGN_CNT  (FOREIGN_CNT),
    .SEQ_ERR_CNT  (SEQ_ERR_CNT),
    .MONO_ERR_CNT (MONO_ERR_CNT)
  );

  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;

  // Stimulus controls
  bit rst_req  = 1'b0;
  bit rst_rand = 1'b0;
  int rdy_mode = 0;   // 0: always ready, 1: random, 2: never
  int en_mode  = 0;   // 0: always enabled, 1: random
  int gap_pct  = 0;

  // Upstream FIFO contents and accepted timestamps
  logic [31:0] fq[$];
  logic [63:0] acc_q[$];

  // Reference model state
  int          m_have;        // own words of the current group collected so far (0..2)
  logic [23:0] m_lo, m_mid;
  bit          m_valid;
  logic [63:0] m_data;
  logic [31:0] m_cnt;
  int          m_foreign, m_seq, m_mono;
  bit          m_last_vld;
  logic [63:0] m_last;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int sat(input int c);
    return (c < int'(MAXC)) ? c + 1 : c;
  endfunction

  task automatic model_reset();
    m_have = 0; m_lo = '0; m_mid = '0;
    m_valid = 1'b0; m_data = '0; m_cnt = '0;
    m_foreign = 0; m_seq = 0; m_mono = 0;
    m_last_vld = 1'b0; m_last = '0;
  endtask

  // Consume one popped word according to the group format rules
  task automatic model_word(input logic [31:0] w, output bit emit, output logic [63:0] v);
    logic [3:0] id, typ;
    id = w[31:28]; typ = w[27:24];
    emit = 1'b0; v = '0;
    if (id != 4'h1) begin
      m_foreign = sat(m_foreign);
    end else if (m_have == 0) begin
      if (typ == 4'h1) begin m_lo = w[23:0]; m_have = 1; end
      else m_seq = sat(m_seq);
    end else if (m_have == 1) begin
      if (typ == 4'h2) begin m_mid = w[23:0]; m_have = 2; end
      else if (typ == 4'h1) begin m_seq = sat(m_seq); m_lo = w[23:0]; m_have = 1; end
      else begin m_seq = sat(m_seq); m_have = 0; end
    end else begin
      if (typ == 4'h3 && w[23:16] == 8'h00) begin
        emit = 1'b1;
        v = {w[15:0], m_mid, m_lo};
        m_have = 0;
      end else if (typ == 4'h1) begin
        m_seq = sat(m_seq); m_lo = w[23:0]; m_have = 1;
      end else begin
        m_seq = sat(m_seq); m_have = 0;
      end
    end
  endtask

  // Advance the model across one rising edge
  task automatic model_step(input bit rd);
    bit          acc, emit;
    logic [63:0] v;
    logic [31:0] w;
    if (!RST_N) begin
      model_reset();
      return;
    end
    acc = m_valid && bus.TS_READY;
    if (acc) acc_q.push_back(bus.TS_DATA);
    emit = 1'b0;
    v = '0;
    if (rd) begin
      w = fq.pop_front();
      model_word(w, emit, v);
    end
    if (emit) begin
      if (m_last_vld && v < m_last) m_mono = sat(m_mono);
      m_last = v; m_last_vld = 1'b1;
      m_cnt = m_cnt + 32'd1;
      m_valid = 1'b1;
      m_data = v;
    end else if (acc) begin
      m_valid = 1'b0;
    end
  endtask

  // One clock: check outputs, drive inputs, predict pop, advance model
  task automatic cycle();
    bit exp_rd;
    @(negedge CLK);
    check("ts_valid", 64'(bus.TS_VALID), 64'(m_valid));
    check("ts_data", bus.TS_DATA, m_data);
    check("ts_cnt", 64'(TS_CNT), 64'(m_cnt));
    check("foreign_cnt", 64'(FOREIGN_CNT), 64'(m_foreign));
    check("seq_err_cnt", 64'(SEQ_ERR_CNT), 64'(m_seq));
    check("mono_err_cnt", 64'(MONO_ERR_CNT), 64'(m_mono));

    RST_N  = !(rst_req || (rst_rand && $urandom_range(0, 299) == 0));
    ENABLE = (en_mode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
    bus.TS_READY = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 2) ? 1'b0 : 1'($urandom_range(0, 1));
    bus.FIFO_EMPTY = (fq.size() == 0) || (gap_pct != 0 && $urandom_range(0, 99) < gap_pct);
    bus.FIFO_DATA  = (fq.size() != 0) ? fq[0] : $urandom;
    #1;
    exp_rd = RST_N && ENABLE && !bus.FIFO_EMPTY && !(m_valid && !bus.TS_READY);
    check("fifo_read", 64'(bus.FIFO_READ), 64'(exp_rd));
    model_step(exp_rd);
    @(posedge CLK);
    #1;
  endtask

  task automatic run_until_idle(input int max);
    int n = 0;
    while ((fq.size() != 0 || m_valid) && n < max) begin
      cycle();
      n++;
    end
    if (fq.size() != 0 || m_valid) check("drain_timeout", 64'd1, 64'd0);
  endtask

  task automatic do_reset();
    rst_req = 1'b1;
    cycle();
    cycle();
    rst_req = 1'b0;
    acc_q.delete();
  endtask

  task automatic push_group(input logic [63:0] ts);
    fq.push_back({4'h1, 4'h1, ts[23:0]});
    fq.push_back({4'h1, 4'h2, ts[47:24]});
    fq.push_back({4'h1, 4'h3, 8'h00, ts[63:48]});
  endtask

  initial begin
    logic [63:0] ts, prev;
    int          kind;
    RST_N = 1'b0; ENABLE = 1'b0;
    bus.FIFO_EMPTY = 1'b1; bus.FIFO_DATA = '0; bus.TS_READY = 1'b0;
    model_reset();
    @(posedge CLK);
    #1;
    do_reset();

    // Basic group
    fq.push_back(32'h11ABCDEF); fq.push_back(32'h12123456); fq.push_back(32'h13007890);
    run_until_idle(50);
    check("t1_count", 64'(acc_q.size()), 64'd1);
    if (acc_q.size() > 0) check("t1_data", acc_q[0], 64'h7890123456ABCDEF);
    check("t1_ts_cnt", 64'(TS_CNT), 64'd1);
    check("t1_seq", 64'(SEQ_ERR_CNT), 64'd0);

    // Foreign word inside a group
    do_reset();
    fq.push_back(32'h11ABCDEF); fq.push_back(32'h12123456);
    fq.push_back(32'h21000005); fq.push_back(32'h13007890);
    run_until_idle(50);
    check("t2_foreign", 64'(FOREIGN_CNT), 64'd1);
    if (acc_q.size() > 0) check("t2_data", acc_q[0], 64'h7890123456ABCDEF);
    else check("t2_count", 64'd0, 64'd1);

    // Sequence errors and restart
    do_reset();
    fq.push_back(32'h11000001); fq.push_back(32'h13000002);
    run_until_idle(50);
    check("t3_seq1", 64'(SEQ_ERR_CNT), 64'd1);
    check("t3_none", 64'(acc_q.size()), 64'd0);
    fq.push_back(32'h11000003); fq.push_back(32'h11000004);
    fq.push_back(32'h12000000); fq.push_back(32'h13000000);
    run_until_idle(50);
    check("t3_seq2", 64'(SEQ_ERR_CNT), 64'd2);
    if (acc_q.size() > 0) check("t3_data", acc_q[0], 64'h0000000000000004);
    else check("t3_count", 64'd0, 64'd1);

    // Backpressure holds the first result and stalls the FIFO
    do_reset();
    rdy_mode = 2;
    push_group(64'h0000222222111111);
    push_group(64'h5555444444333333);
    repeat (20) cycle();
    check("t4_valid", 64'(bus.TS_VALID), 64'd1);
    check("t4_hold", bus.TS_DATA, 64'h0000222222111111);
    check("t4_read", 64'(bus.FIFO_READ), 64'd0);
    check("t4_left", 64'(fq.size()), 64'd3);
    rdy_mode = 0;
    run_until_idle(50);
    check("t4_count", 64'(acc_q.size()), 64'd2);
    if (acc_q.size() == 2) begin
      check("t4_first", acc_q[0], 64'h0000222222111111);
      check("t4_second", acc_q[1], 64'h5555444444333333);
    end
    check("t4_ts_cnt", 64'(TS_CNT), 64'd2);

    // Monotonicity and malformed word 3
    do_reset();
    push_group(64'h100);
    push_group(64'h0FF);
    run_until_idle(50);
    check("t5_mono", 64'(MONO_ERR_CNT), 64'd1);
    check("t5_count", 64'(acc_q.size()), 64'd2);
    fq.push_back(32'h11000001); fq.push_back(32'h12000000); fq.push_back(32'h13FF0000);
    run_until_idle(50);
    check("t5_seq", 64'(SEQ_ERR_CNT), 64'd1);
    check("t5_noout", 64'(acc_q.size()), 64'd2);

    // Reset mid-group discards partial data
    do_reset();
    push_group(64'h0000000000ABCDEF);
    fq.push_back(32'h11000001); fq.push_back(32'h12000002);
    run_until_idle(50);
    rst_req = 1'b1;
    cycle();
    rst_req = 1'b0;
    check("t6_valid0", 64'(bus.TS_VALID), 64'd0);
    check("t6_data0", bus.TS_DATA, 64'd0);
    check("t6_cnt0", 64'(TS_CNT), 64'd0);
    check("t6_mono0", 64'(MONO_ERR_CNT), 64'd0);
    acc_q.delete();
    fq.push_back(32'h13000003);
    run_until_idle(50);
    check("t6_seq", 64'(SEQ_ERR_CNT), 64'd1);
    check("t6_noout", 64'(acc_q.size()), 64'd0);

    // Counter saturation
    do_reset();
    repeat (20) fq.push_back(32'h2F000000);
    repeat (20) fq.push_back(32'h10000000);
    run_until_idle(100);
    check("sat_foreign", 64'(FOREIGN_CNT), 64'(MAXC));
    check("sat_seq", 64'(SEQ_ERR_CNT), 64'(MAXC));

    // Randomized traffic with backpressure, enable toggling, gaps and resets
    rdy_mode = 1; en_mode = 1; gap_pct = 20; rst_rand = 1'b1;
    prev = '0;
    for (int b = 0; b < 40; b++) begin
      if (b % 4 == 0) do_reset();
      for (int i = 0; i < 8; i++) begin
        kind = $urandom_range(0, 9);
        if (kind < 6) begin
          ts = ($urandom_range(0, 1) != 0) ? prev + 64'($urandom_range(0, 300)) - 64'd100
                                           : {$urandom, $urandom};
          push_group(ts);
          prev = ts;
        end else if (kind == 6) begin
          fq.push_back({4'($urandom_range(2, 15)), 28'($urandom)});
        end else if (kind == 7) begin
          fq.push_back({4'h1, 28'($urandom)});
        end else begin
          ts = {$urandom, $urandom};
          fq.push_back({4'h1, 4'h1, ts[23:0]});
          if (kind == 9) fq.push_back({4'h1, 4'h2, ts[47:24]});
        end
      end
      run_until_idle(2000);
    end
    rst_rand = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
